// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Mem port arbiter.
// MemOp codes match the encoding Data_Mem decodes (size in [1:0], unsigned in [2]).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

endpackage

// File: rtl/dmem_arb_pick.sv
// Tie-break between CPU and debug requesters; a lone requester always wins.
// DMEM_ARB_RR_EN selects round-robin; otherwise CPU priority with a debug starvation bound.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    decide,
  output req_id_t winner
);

`ifdef DMEM_ARB_RR_EN
  req_id_t last;

  always_comb begin
    winner = REQ_CPU;
    if (dbg_req && !cpu_req) begin
      winner = REQ_DBG;
    end else if (cpu_req && dbg_req) begin
      winner = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end
  end

  // Reset to debug so the CPU takes the first tie.
  always_ff @(posedge clk) begin
    if (clr) begin
      last <= REQ_DBG;
    end else if (decide) begin
      last <= winner;
    end
  end
`else
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] dbg_wait;
  logic          starved;

  assign starved = (dbg_wait == WW'(MAX_WAIT));

  always_comb begin
    winner = REQ_CPU;
    if (dbg_req && (!cpu_req || starved)) begin
      winner = REQ_DBG;
    end
  end

  // Only decisions the CPU takes while debug is waiting count as refusals.
  always_ff @(posedge clk) begin
    if (clr) begin
      dbg_wait <= '0;
    end else if (decide) begin
      if (winner == REQ_DBG) begin
        dbg_wait <= '0;
      end else if (dbg_req && !starved) begin
        dbg_wait <= dbg_wait + 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the Data_Mem port between the CPU load/store port and a debug/loader port.
// Tie-break policy is chosen by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          clr,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [2:0]    cpu_memop,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [2:0]    dbg_memop,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_memop,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_rdata
);

  state_t  state, state_nxt;
  req_id_t winner, owner;
  logic    decide;

  assign decide = (state == IDLE) && (cpu_req || dbg_req);

  dmem_arb_pick #(
    .MAX_WAIT(MAX_WAIT)
  ) u_pick (
    .clk    (CLK),
    .clr    (clr),
    .cpu_req(cpu_req),
    .dbg_req(dbg_req),
    .decide (decide),
    .winner (winner)
  );

  always_ff @(posedge CLK) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In ISSUE, mem_wren holds the winner's we and so distinguishes store from load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (decide) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_wren ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      owner      <= REQ_CPU;
      mem_addr   <= '0;
      mem_memop  <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      mem_wren   <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      if (decide) begin
        owner <= winner;
        if (winner == REQ_DBG) begin
          mem_addr  <= dbg_addr;
          mem_memop <= dbg_memop;
          mem_wdata <= dbg_wdata;
          mem_wren  <= dbg_we;
          dbg_gnt   <= 1'b1;
        end else begin
          mem_addr  <= cpu_addr;
          mem_memop <= cpu_memop;
          mem_wdata <= cpu_wdata;
          mem_wren  <= cpu_we;
          cpu_gnt   <= 1'b1;
        end
      end
      if (state == RESP) begin
        if (owner == REQ_DBG) begin
          dbg_rdata  <= mem_rdata;
          dbg_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= mem_rdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
